// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the decoder slice that
// drives it from the SPECIAL-opcode funct field.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_ITER = 32;

  typedef struct packed {
    logic    start;
    mdu_op_e op;
    logic    wr_hi;
    logic    wr_lo;
  } mdu_dec_t;

  function automatic logic mdu_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // MFHI/MFLO need no MDU action; they read hi/lo directly.
  function automatic mdu_dec_t mdu_decode(input logic [5:0] funct);
    mdu_dec_t d;
    d = '{start: 1'b0, op: MDU_MULT, wr_hi: 1'b0, wr_lo: 1'b0};
    case (funct)
      6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
        d.start = 1'b1;
        d.op    = mdu_op_e'(funct[1:0]);
      end
      6'b010001: d.wr_hi = 1'b1;
      6'b010011: d.wr_lo = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu32_if.sv
// Request/response bundle between the execute-stage controller and mdu32.
interface mdu32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a_in, b_in, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a_in, b_in, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude on entry, sign restore on exit.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (~val + 1'b1) : val;
endmodule

// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit owning HI/LO; one bit per cycle,
// 34 cycles start-to-done, sign handled by magnitude in / negate out.
module mdu32
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic    clock,
  input logic    reset,
  mdu32_if.slave bus
);

  mdu_state_e         state;
  mdu_op_e            op_q;
  logic               a_neg, b_neg, b_zero;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Operand magnitudes, index 0 = rs (a), index 1 = rt (b)
  logic                   in_signed;
  logic [1:0][WIDTH-1:0]  in_raw, in_mag;
  logic [1:0]             in_neg;

  assign in_signed = mdu_is_signed(mdu_op_e'(bus.op));
  assign in_raw    = {bus.b_in, bus.a_in};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_mag
      assign in_neg[i] = in_signed & in_raw[i][WIDTH-1];
      mdu_sign_fix #(.W(WIDTH)) u_mag (
        .val (in_raw[i]),
        .neg (in_neg[i]),
        .res (in_mag[i])
      );
    end
  endgenerate

  // Multiply keeps the product in acc; divide keeps {remainder, quotient/dividend}.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_b};
    div_next  = {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  logic               res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign res_neg = a_neg ^ b_neg;

  mdu_sign_fix #(.W(2*WIDTH)) u_prod (.val(acc),                   .neg(res_neg), .res(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_quo  (.val(acc[WIDTH-1:0]),        .neg(res_neg), .res(quo_fix));
  // Remainder follows the dividend; for x/0 this restores the raw dividend.
  mdu_sign_fix #(.W(WIDTH))   u_rem  (.val(acc[2*WIDTH-1:WIDTH]),  .neg(a_neg),   .res(rem_fix));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= MDU_IDLE;
      op_q   <= MDU_MULT;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (bus.wr_hi) hi_q <= bus.wr_data;
          if (bus.wr_lo) lo_q <= bus.wr_data;
          if (bus.start) begin
            op_q   <= mdu_op_e'(bus.op);
            a_neg  <= in_neg[0];
            b_neg  <= in_neg[1];
            b_zero <= (bus.b_in == '0);
            mag_a  <= in_mag[0];
            mag_b  <= in_mag[1];
            acc    <= {{WIDTH{1'b0}}, (mdu_is_div(mdu_op_e'(bus.op)) ? in_mag[0] : in_mag[1])};
            cnt    <= '0;
            state  <= MDU_CALC;
          end
        end
        MDU_CALC: begin
          acc <= mdu_is_div(op_q) ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(MDU_ITER - 1)) state <= MDU_FIX;
        end
        MDU_FIX: begin
          if (mdu_is_div(op_q)) begin
            hi_q <= rem_fix;
            lo_q <= b_zero ? '1 : quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
          state  <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != MDU_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu32.sv
// Directed bench for mdu32: latency window, signed/unsigned results,
// divide-by-zero, overflow, MT writes, collisions and mid-op reset.
module tb_mdu32;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mdu32_if #(.WIDTH(32)) bus ();
  mdu32 #(.WIDTH(32)) dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the current cycle N and returns in cycle N+34 (done cycle),
  // so a following call issues back-to-back.
  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int bad;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      tick();
    end
    check({tag, "_busy_win"}, 64'(bad), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hi"},   64'(bus.hi),   64'(exp_hi));
    check({tag, "_lo"},   64'(bus.lo),   64'(exp_lo));
  endtask

  initial begin
    int seen;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = MDU_MULT;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    tick();

    // MT writes in IDLE
    bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    tick();
    bus.wr_hi = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'h0000_0000_A5A5A5A5);
    check("mthi_lo", 64'(bus.lo), 64'd0);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h13572468;
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    check("mtboth_hi", 64'(bus.hi), 64'h0000_0000_13572468);
    check("mtboth_lo", 64'(bus.lo), 64'h0000_0000_13572468);

    // Back-to-back arithmetic
    run_op("mult_7_m3",     MDU_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max",     MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_min_min",  MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("mult_m2_m3",    MDU_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    run_op("div_m7_2",      MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_100_m7",    MDU_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
    run_op("divu_7_2",      MDU_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003);
    run_op("divu_by0",      MDU_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_op("div_neg_by0",   MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",       MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    tick();
    check("done_pulse_end", 64'(bus.done), 64'd0);
    check("idle_busy",      64'(bus.busy), 64'd0);

    // start together with MTHI: MT lands first, FIX result overwrites it
    bus.op = MDU_MULTU; bus.a_in = 32'd3; bus.b_in = 32'd4;
    bus.start = 1'b1; bus.wr_hi = 1'b1; bus.wr_data = 32'h11111111;
    tick();
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    check("coll_mthi_hi", 64'(bus.hi),   64'h0000_0000_11111111);
    check("coll_busy",    64'(bus.busy), 64'd1);
    repeat (3) tick();
    // MTLO and a second start while in CALC are dropped
    bus.wr_lo = 1'b1; bus.wr_data = 32'hDEADBEEF;
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a_in = 32'd100; bus.b_in = 32'd3;
    tick();
    bus.wr_lo = 1'b0; bus.start = 1'b0;
    check("calc_mtlo_drop", 64'(bus.lo), 64'h0000_0000_80000000);
    repeat (29) tick();
    check("coll_done", 64'(bus.done), 64'd1);
    check("coll_hi",   64'(bus.hi),   64'd0);
    check("coll_lo",   64'(bus.lo),   64'd12);
    tick();
    check("calc_start_drop", 64'(bus.busy), 64'd0);

    // Reset in cycle N+10 of a DIV
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hCAFEF00D;
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.op = MDU_DIV; bus.a_in = 32'hFFFFFFF9; bus.b_in = 32'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_hi",   64'(bus.hi),   64'd0);
    check("mid_rst_lo",   64'(bus.lo),   64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
      tick();
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    run_op("post_rst_multu", MDU_MULTU, 32'd2, 32'd3, 32'h00000000, 32'h00000006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
